demux_fifo_2ch: RTL and testbench

Two-lane demultiplexer with per-lane buffering: the inverse of the 2:1 selector mux. Accepts one DATA_W-bit input stream and steers each valid word into lane 0 or lane 1 by `selector`, holding it in a small per-lane FIFO until the downstream consumer pops it. It sits on the receive side of the mux datapath, so the mux and demux can run back-to-back in the same bench. Overflow words are dropped and counted.

---
 rtl/demux_fifo_2ch.sv | 140 ++++++++++++++
 tb/tb_demux_fifo_2ch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_fifo_2ch.sv
// demux_fifo_2ch: steers one input word stream into two show-ahead lane FIFOs by selector.
// Latency: a word pushed at edge k is visible on data_outN during cycle k+1; all outputs come from registers.
// Backpressure: none upstream; a push to a full lane without a same-lane pop is dropped and counted (saturating).
//
// Ports:
//   clk, reset_L                    single clock, asynchronous active-low reset
//   valid_in, selector, data_in     push side: word, target lane (0/1)
//   pop0, pop1                      consumer takes the head of lane 0 / lane 1
//   data_outN, valid_outN, fullN    lane head word (0 when empty), non-empty flag, full flag
//   drop_cnt                        count of words dropped on overflow, saturating

// demux_fifo_2ch_fifo: one lane, circular buffer with show-ahead head and occupancy count.
// Latency: push visible after the next edge; pop consumes the head at the edge.
// Backpressure: reports o_drop when a push hits a full lane with no pop in the same cycle.
module demux_fifo_2ch_fifo #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_vld,
  output logic              o_full,
  output logic              o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_cnt;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_FULL);
  // A pop on an empty lane is ignored, even when a push arrives the same cycle.
  assign w_pop_ok  = i_pop & ~w_empty;
  // A full lane still accepts a push when its head is freed in the same cycle.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push_ok && w_pop_ok) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_dat  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_vld  = ~w_empty;
  assign o_full = w_full;
  assign o_drop = i_push & ~w_push_ok;
endmodule

// demux_fifo_2ch: top, two lanes plus the shared saturating drop counter.
// Latency: one edge from push to head visibility; no input-to-output combinational path.
// Backpressure: none; overflow words are discarded and counted in drop_cnt.
module demux_fifo_2ch #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic              selector,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop0,
  input  logic              pop1,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              full0,
  output logic              full1,
  output logic [CNT_W-1:0]  drop_cnt
);
  logic             w_push0;
  logic             w_push1;
  logic             w_drop0;
  logic             w_drop1;
  logic [CNT_W-1:0] r_drop_cnt;

  assign w_push0 = valid_in & ~selector;
  assign w_push1 = valid_in &  selector;

  demux_fifo_2ch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane0 (
    .clk     (clk),
    .reset_L (reset_L),
    .i_push  (w_push0),
    .i_dat   (data_in),
    .i_pop   (pop0),
    .o_dat   (data_out0),
    .o_vld   (valid_out0),
    .o_full  (full0),
    .o_drop  (w_drop0)
  );

  demux_fifo_2ch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
    .clk     (clk),
    .reset_L (reset_L),
    .i_push  (w_push1),
    .i_dat   (data_in),
    .i_pop   (pop1),
    .o_dat   (data_out1),
    .o_vld   (valid_out1),
    .o_full  (full1),
    .o_drop  (w_drop1)
  );

  // Only one lane is pushed per cycle, so at most one drop per edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_drop_cnt <= '0;
    end else if ((w_drop0 | w_drop1) && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_demux_fifo_2ch.sv
// Bench for demux_fifo_2ch: directed test-plan sequences plus random traffic.
// The driver keeps a queue-based lane model and checks flags/heads each cycle;
// a separate monitor checks every popped word against per-lane scoreboards.
module tb_demux_fifo_2ch;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 6;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset_L;
  logic              valid_in;
  logic              selector;
  logic [DATA_W-1:0] data_in;
  logic              pop0;
  logic              pop1;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic              valid_out0;
  logic              valid_out1;
  logic              full0;
  logic              full1;
  logic [CNT_W-1:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: lane contents and drop count.
  int m0[$];
  int m1[$];
  int m_drop = 0;
  // Scoreboards: words expected to leave each lane, in order.
  int sb0[$];
  int sb1[$];

  demux_fifo_2ch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .valid_in   (valid_in),
    .selector   (selector),
    .data_in    (data_in),
    .pop0       (pop0),
    .pop1       (pop1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .full0      (full0),
    .full1      (full1),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT-visible state with the model (called #1 after a rising edge).
  task automatic check_state(input string tag);
    chk({tag, "_valid0"}, int'(valid_out0), int'(m0.size() != 0));
    chk({tag, "_valid1"}, int'(valid_out1), int'(m1.size() != 0));
    chk({tag, "_full0"},  int'(full0),      int'(m0.size() == DEPTH));
    chk({tag, "_full1"},  int'(full1),      int'(m1.size() == DEPTH));
    chk({tag, "_data0"},  int'(data_out0),  (m0.size() != 0) ? m0[0] : 0);
    chk({tag, "_data1"},  int'(data_out1),  (m1.size() != 0) ? m1[0] : 0);
    chk({tag, "_drop"},   int'(drop_cnt),   m_drop);
  endtask

  // Apply one lane's rules for the upcoming edge.
  task automatic model_lane(input bit push, input bit pop, input int d,
                            inout int q[$], inout int sb[$]);
    bit pop_ok;
    bit was_full;
    pop_ok   = pop && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    if (pop_ok) void'(q.pop_front());
    if (push) begin
      if (!was_full || pop_ok) begin
        q.push_back(d);
        sb.push_back(d);
      end else if (m_drop < DROP_MAX) begin
        m_drop++;
      end
    end
  endtask

  // One cycle: check state after the previous edge, then drive inputs for the next edge.
  task automatic step(input string tag, input bit v, input bit sel, input int d,
                      input bit p0, input bit p1);
    @(posedge clk);
    #1;
    check_state(tag);
    valid_in = v;
    selector = sel;
    data_in  = DATA_W'(d);
    pop0     = p0;
    pop1     = p1;
    model_lane(v && !sel, p0, d, m0, sb0);
    model_lane(v &&  sel, p1, d, m1, sb1);
  endtask

  // Monitor: each accepted pop must deliver the scoreboard's next word.
  initial begin
    int exp;
    forever begin
      @(negedge clk);
      if (reset_L && pop0 && valid_out0) begin
        if (sb0.size() == 0) begin
          checks++; errors++;
          $display("FAIL lane0_pop: got %0d expected no word (scoreboard empty)", data_out0);
        end else begin
          exp = sb0.pop_front();
          chk("lane0_pop", int'(data_out0), exp);
        end
      end
      if (reset_L && pop1 && valid_out1) begin
        if (sb1.size() == 0) begin
          checks++; errors++;
          $display("FAIL lane1_pop: got %0d expected no word (scoreboard empty)", data_out1);
        end else begin
          exp = sb1.pop_front();
          chk("lane1_pop", int'(data_out1), exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    selector = 1'b0;
    data_in  = '0;
    pop0     = 1'b0;
    pop1     = 1'b0;
    #12 reset_L = 1'b1;

    // Reset state, then two words into lane 0 before a mid-stream reset.
    step("reset",  1, 0, 2, 0, 0);
    step("pre1",   1, 0, 3, 0, 0);
    step("pre2",   0, 0, 0, 0, 0);
    // Lane 0 now holds 2 words; reset without waiting for an edge.
    chk("pre_rst_valid0", int'(valid_out0), 1);
    #2 reset_L = 1'b0;
    #1;
    chk("rst_valid0", int'(valid_out0), 0);
    chk("rst_valid1", int'(valid_out1), 0);
    chk("rst_data0",  int'(data_out0),  0);
    chk("rst_data1",  int'(data_out1),  0);
    chk("rst_full0",  int'(full0),      0);
    chk("rst_full1",  int'(full1),      0);
    chk("rst_drop",   int'(drop_cnt),   0);
    m0.delete(); m1.delete(); sb0.delete(); sb1.delete(); m_drop = 0;
    @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;

    // Steering: 01->lane0, 10->lane1, 11->lane0, then pop lane 0.
    step("post_rst", 1, 0, 1, 0, 0);
    step("steer1",   1, 1, 2, 0, 0);
    step("steer2",   1, 0, 3, 0, 0);
    step("steer3",   0, 0, 0, 1, 0);
    step("steer4",   0, 0, 0, 0, 0);
    chk("steer_data0_after_pop", int'(data_out0), 3);
    // Both lanes hold one word; pop both together, then pop empty lane 0.
    step("dualpop",  0, 0, 0, 1, 1);
    step("emptypop", 0, 0, 0, 1, 0);
    step("idle0",    0, 0, 0, 0, 0);
    chk("dualpop_valid0", int'(valid_out0), 0);
    chk("dualpop_valid1", int'(valid_out1), 0);
    chk("emptypop_data0", int'(data_out0),  0);

    // Fill/overflow lane 0: 00,01,10,11,01; then drain.
    step("fill0", 1, 0, 0, 0, 0);
    step("fill1", 1, 0, 1, 0, 0);
    step("fill2", 1, 0, 2, 0, 0);
    step("fill3", 1, 0, 3, 0, 0);
    step("fill4", 1, 0, 1, 0, 0);
    chk("fill_full0", int'(full0), 1);
    for (int i = 0; i < 4; i++) step("drain0", 0, 0, 0, 1, 0);
    step("drain0_end", 0, 0, 0, 0, 0);
    chk("overflow_drop", int'(drop_cnt), 1);
    chk("drained_valid0", int'(valid_out0), 0);

    // Lane 1 full, then push 11 with pop1: accepted, not dropped.
    for (int i = 0; i < 4; i++) step("fill_l1", 1, 1, i, 0, 0);
    step("pushpop1", 1, 1, 3, 0, 1);
    step("pushpop1_chk", 0, 0, 0, 0, 0);
    chk("pushpop_full1", int'(full1), 1);
    chk("pushpop_drop",  int'(drop_cnt), 1);
    for (int i = 0; i < 4; i++) step("drain1", 0, 0, 0, 0, 1);

    // Random traffic, biased toward pushes so lanes fill and drop.
    for (int i = 0; i < 1500; i++) begin
      step("rand", ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
           $urandom_range(0, 3), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
    end
    for (int i = 0; i < 6; i++) step("rand_drain", 0, 0, 0, 1, 1);

    // Saturation: fill lane 0 then push 70 more with no pops.
    for (int i = 0; i < 4; i++) step("sat_fill", 1, 0, i, 0, 0);
    for (int i = 0; i < 70; i++) step("sat", 1, 0, $urandom_range(0, 3), 0, 0);
    step("sat_end", 0, 0, 0, 0, 0);
    chk("sat_drop", int'(drop_cnt), DROP_MAX);
    for (int i = 0; i < 5; i++) step("sat_drain", 0, 0, 0, 1, 0);
    step("final", 0, 0, 0, 0, 0);
    chk("final_drop", int'(drop_cnt), DROP_MAX);

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
